cacheline_adapter: RTL and testbench

Memory-side responder for the cache `dfp_*` port. It accepts one 256-bit cache-line read or write request from a cache such as the instruction or data cache. It converts the request into a 4-beat, 64-bit burst on the banked memory (`bmem_*`) interface. It returns a single-cycle `dfp_resp`, with the assembled line on reads. It sits between each cache and the memory arbiter.

---
 rtl/cacheline_adapter.sv | 128 ++++++++++++
 tb/tb_cacheline_adapter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// Cache-line to memory-burst adapter: turns one dfp line read/write into a
// BEATS-long burst on the bmem port and answers with a one-cycle dfp_resp.
module cacheline_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, RESP} state_t;

    state_t            state;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] line_q;
    logic [CNT_W-1:0]  cnt;

    logic [CNT_W-1:0]  cnt_inc;
    logic              beat_hit;
    logic [LINE_W-1:0] line_fill;

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return {a[31:OFF_W], OFF_W'(0)};
    endfunction

    // Read beats tagged with another line's address belong to someone else.
    always_comb begin
        cnt_inc   = cnt + CNT_W'(1);
        beat_hit  = bmem_rvalid && (bmem_raddr == addr_q);
        line_fill = line_q;
        line_fill[int'(cnt)*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            line_q     <= '0;
            cnt        <= '0;
            dfp_rdata  <= '0;
            dfp_resp   <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            dfp_resp <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Write wins if a misbehaving cache raises both requests.
                    if (dfp_write) begin
                        addr_q     <= line_align(dfp_addr);
                        line_q     <= dfp_wdata;
                        bmem_addr  <= line_align(dfp_addr);
                        bmem_write <= 1'b1;
                        bmem_wdata <= dfp_wdata[BEAT_W-1:0];
                        state      <= WR_DATA;
                    end else if (dfp_read) begin
                        addr_q    <= line_align(dfp_addr);
                        bmem_addr <= line_align(dfp_addr);
                        bmem_read <= 1'b1;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        bmem_addr <= '0;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (beat_hit) begin
                        line_q <= line_fill;
                        cnt    <= cnt_inc;
                        if (cnt == LAST) begin
                            dfp_resp  <= 1'b1;
                            dfp_rdata <= line_fill;
                            state     <= RESP;
                        end
                    end
                end
                WR_DATA: begin
                    if (bmem_ready) begin
                        cnt <= cnt_inc;
                        if (cnt == LAST) begin
                            bmem_write <= 1'b0;
                            bmem_addr  <= '0;
                            bmem_wdata <= '0;
                            dfp_resp   <= 1'b1;
                            dfp_rdata  <= line_q;
                            state      <= RESP;
                        end else begin
                            bmem_wdata <= line_q[int'(cnt_inc)*BEAT_W +: BEAT_W];
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Bench for cacheline_adapter: table of line transactions driven against a
// small memory model, with responses checked through a scoreboard queue.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst_n;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    cacheline_adapter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        bit           both;
        bit           inject;
        bit           rst_mid;
        int           stall_beat;
        int           stall_cycles;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [31:0]  exp_addr;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t         vecs[8];
    logic [255:0] sb_q[$];
    int           errors = 0;
    int           checks = 0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 256'(act), 256'(exp));
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, 256'(act), 256'(exp));
    endtask

    task automatic outputs_zero(input string tag);
        chk1({tag, "_resp"}, dfp_resp, 1'b0);
        chk({tag, "_rdata"}, dfp_rdata, 256'd0);
        chk1({tag, "_bread"}, bmem_read, 1'b0);
        chk1({tag, "_bwrite"}, bmem_write, 1'b0);
        chk32({tag, "_baddr"}, bmem_addr, 32'd0);
        chk({tag, "_bwdata"}, 256'(bmem_wdata), 256'd0);
    endtask

    task automatic sb_pop_check(input string name);
        logic [255:0] exp;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected resp with rdata %h, nothing expected", name, dfp_rdata);
        end else begin
            exp = sb_q.pop_front();
            if (dfp_rdata !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, dfp_rdata, exp);
            end
        end
    endtask

    task automatic run_read(input vec_t v);
        int lat;
        if (!v.rst_mid) sb_q.push_back(v.exp_rdata);
        dfp_addr   = v.addr;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        tick();
        chk1("rd_req", bmem_read, 1'b1);
        chk32("rd_addr", bmem_addr, v.exp_addr);
        tick();
        chk1("rd_pulse", bmem_read, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (v.inject && i == 2) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = 32'hFFFF_FFE0;
                bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
                tick();
            end
            if (v.rst_mid && i == 2) begin
                rst_n       = 1'b0;
                dfp_read    = 1'b0;
                bmem_rvalid = 1'b0;
                #1;
                outputs_zero("rst_mid");
                tick();
                rst_n = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    tick();
                    chk1("rst_no_resp", dfp_resp, 1'b0);
                end
                return;
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = v.exp_addr;
            bmem_rdata  = v.data[i*64 +: 64];
            tick();
        end
        bmem_rvalid = 1'b0;
        lat = 0;
        while (!dfp_resp && lat < 8) begin
            tick();
            lat++;
        end
        chk32("rd_resp_lat", 32'(lat), 32'd0);
        if (dfp_resp) sb_pop_check("rd_line");
        dfp_read = 1'b0;
        tick();
        chk1("rd_resp_1cyc", dfp_resp, 1'b0);
    endtask

    task automatic run_write(input vec_t v);
        int b = 0;
        int stalled = 0;
        bit got = 0;
        sb_q.push_back(v.exp_rdata);
        dfp_addr   = v.addr;
        dfp_wdata  = v.data;
        dfp_write  = 1'b1;
        dfp_read   = v.both;
        bmem_ready = 1'b1;
        for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
            tick();
            chk1("wr_no_read", bmem_read, 1'b0);
            if (dfp_resp) begin
                got = 1;
                chk32("wr_resp_cycle", 32'(cyc), 32'(5 + v.stall_cycles));
                sb_pop_check("wr_line");
            end else begin
                chk1("wr_valid", bmem_write, 1'b1);
                chk32("wr_addr", bmem_addr, v.exp_addr);
                chk("wr_beat", 256'(bmem_wdata), 256'(v.data[b*64 +: 64]));
                if (b == v.stall_beat && stalled < v.stall_cycles) begin
                    bmem_ready = 1'b0;
                    stalled++;
                end else begin
                    bmem_ready = 1'b1;
                    b++;
                end
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL wr_timeout: got no resp expected resp within 20 cycles");
        end
        dfp_write = 1'b0;
        dfp_read  = 1'b0;
        tick();
        chk1("wr_resp_1cyc", dfp_resp, 1'b0);
    endtask

    initial begin
        vecs[0] = '{wr:0, both:0, inject:0, rst_mid:0, stall_beat:-1, stall_cycles:0,
                    addr:32'h0000_1234,
                    data:{64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    exp_addr:32'h0000_1220,
                    exp_rdata:{64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{wr:1, both:0, inject:0, rst_mid:0, stall_beat:-1, stall_cycles:0,
                    addr:32'h0000_0040,
                    data:{64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    exp_addr:32'h0000_0040,
                    exp_rdata:{64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}};
        vecs[2] = '{wr:1, both:0, inject:0, rst_mid:0, stall_beat:2, stall_cycles:3,
                    addr:32'h0000_801F,
                    data:{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                          64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
                    exp_addr:32'h0000_8000,
                    exp_rdata:{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                               64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}};
        vecs[3] = '{wr:0, both:0, inject:1, rst_mid:0, stall_beat:-1, stall_cycles:0,
                    addr:32'h0000_2468,
                    data:{64'hA4A4_A4A4_0000_0004, 64'hA3A3_A3A3_0000_0003,
                          64'hA2A2_A2A2_0000_0002, 64'hA1A1_A1A1_0000_0001},
                    exp_addr:32'h0000_2460,
                    exp_rdata:{64'hA4A4_A4A4_0000_0004, 64'hA3A3_A3A3_0000_0003,
                               64'hA2A2_A2A2_0000_0002, 64'hA1A1_A1A1_0000_0001}};
        vecs[4] = '{wr:1, both:1, inject:0, rst_mid:0, stall_beat:-1, stall_cycles:0,
                    addr:32'h0000_0300,
                    data:{64'h7777_0000_0000_0004, 64'h6666_0000_0000_0003,
                          64'h5555_0000_0000_0002, 64'h4444_0000_0000_0001},
                    exp_addr:32'h0000_0300,
                    exp_rdata:{64'h7777_0000_0000_0004, 64'h6666_0000_0000_0003,
                               64'h5555_0000_0000_0002, 64'h4444_0000_0000_0001}};
        vecs[5] = '{wr:0, both:0, inject:0, rst_mid:1, stall_beat:-1, stall_cycles:0,
                    addr:32'h0000_0500,
                    data:{4{64'hBAD0_BAD0_BAD0_BAD0}},
                    exp_addr:32'h0000_0500,
                    exp_rdata:256'd0};
        vecs[6] = '{wr:0, both:0, inject:0, rst_mid:0, stall_beat:-1, stall_cycles:0,
                    addr:32'h0000_05A7,
                    data:{64'h1357_9BDF_0000_0004, 64'h2468_ACE0_0000_0003,
                          64'hC0DE_C0DE_0000_0002, 64'hFACE_FACE_0000_0001},
                    exp_addr:32'h0000_05A0,
                    exp_rdata:{64'h1357_9BDF_0000_0004, 64'h2468_ACE0_0000_0003,
                               64'hC0DE_C0DE_0000_0002, 64'hFACE_FACE_0000_0001}};
        vecs[7] = '{wr:1, both:0, inject:0, rst_mid:0, stall_beat:0, stall_cycles:1,
                    addr:32'hFFFF_FFFF,
                    data:{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                          64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE},
                    exp_addr:32'hFFFF_FFE0,
                    exp_rdata:{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                               64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE}};

        rst_n       = 1'b0;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        outputs_zero("reset");
        rst_n = 1'b1;
        tick();
        chk1("idle_no_resp", dfp_resp, 1'b0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) run_write(vecs[i]);
            else run_read(vecs[i]);
        end

        chk32("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
